// File: rtl/chan_scanner.sv
// chan_scanner: steps a 3-to-8 demux select through the enabled channels,
// holding each for dwell+1 cycles, in single-pass or continuous mode.
module chan_scanner #(
   parameter int DWELL_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_single,
   input  logic [7:0]         i_en_mask,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic [2:0]         o_s,
   output logic               o_s_valid,
   output logic               o_busy,
   output logic               o_pass_done,
   output logic               o_err_nomask
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t             r_state, w_state_nx;
   logic [2:0]         r_s, w_s_nx, w_first, w_adv;
   logic               r_s_valid, w_s_valid_nx;
   logic               r_pass_done, w_pass_done_nx;
   logic               r_err, w_err_nx;
   logic               r_single, w_single_nx;
   logic               w_wrap;
   logic [7:0]         r_mask, w_mask_nx;
   logic [DWELL_W-1:0] r_dwell, w_dwell_nx, r_cnt, w_cnt_nx;
   // w_first: lowest enabled input channel; w_adv: next enabled channel above r_s, wrapping
   always_comb begin
      w_first = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (i_en_mask[i]) w_first = 3'(i);
      w_adv  = r_s;
      w_wrap = 1'b0;
      for (int k = 8; k >= 1; k--)
         if (r_mask[3'(int'(r_s) + k)]) begin
            w_adv  = 3'(int'(r_s) + k);
            w_wrap = (int'(r_s) + k) >= 8;
         end
   end
   always_comb begin
      w_state_nx     = r_state;
      w_s_nx         = r_s;
      w_s_valid_nx   = r_s_valid;
      w_cnt_nx       = r_cnt;
      w_mask_nx      = r_mask;
      w_dwell_nx     = r_dwell;
      w_single_nx    = r_single;
      w_pass_done_nx = 1'b0;
      w_err_nx       = 1'b0;
      if (r_state == IDLE) begin
         if (i_start && !i_stop && |i_en_mask) begin
            w_state_nx   = SCAN;
            w_mask_nx    = i_en_mask;
            w_dwell_nx   = i_dwell;
            w_single_nx  = i_single;
            w_s_nx       = w_first;
            w_s_valid_nx = 1'b1;
            w_cnt_nx     = i_dwell;
         end else if (i_start && !i_stop) begin
            w_err_nx = 1'b1;
         end
      end else if (i_stop) begin
         w_state_nx   = IDLE;
         w_s_nx       = 3'd0;
         w_s_valid_nx = 1'b0;
         w_cnt_nx     = '0;
      end else if (r_cnt != '0) begin
         w_cnt_nx = r_cnt - DWELL_W'(1);
      end else begin
         w_s_nx         = w_adv;
         w_cnt_nx       = r_dwell;
         w_pass_done_nx = w_wrap;
         if (w_wrap && r_single) begin
            w_state_nx   = IDLE;
            w_s_nx       = 3'd0;
            w_s_valid_nx = 1'b0;
            w_cnt_nx     = '0;
         end
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_s         <= 3'd0;
         r_s_valid   <= 1'b0;
         r_cnt       <= '0;
         r_mask      <= 8'd0;
         r_dwell     <= '0;
         r_single    <= 1'b0;
         r_pass_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_s         <= w_s_nx;
         r_s_valid   <= w_s_valid_nx;
         r_cnt       <= w_cnt_nx;
         r_mask      <= w_mask_nx;
         r_dwell     <= w_dwell_nx;
         r_single    <= w_single_nx;
         r_pass_done <= w_pass_done_nx;
         r_err       <= w_err_nx;
      end
   end
   assign o_s          = r_s;
   assign o_s_valid    = r_s_valid;
   assign o_busy       = (r_state == SCAN);
   assign o_pass_done  = r_pass_done;
   assign o_err_nomask = r_err;
endmodule

// File: tb/tb_chan_scanner.sv
// tb_chan_scanner: per-cycle directed vectors for chan_scanner, plus a
// maximum-dwell sequence.
module tb_chan_scanner;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0, start = 1'b0, stop = 1'b0, single = 1'b0;
   logic [7:0] en_mask = 8'd0, dwell = 8'd0;
   logic [2:0] s;
   logic       s_valid, busy, pass_done, err_nomask;
   int         n_vec = 0, n_err = 0;

   typedef struct {
      string      name;
      logic       rst_n, start, stop, single;
      logic [7:0] mask, dwell;
      logic [2:0] s;
      logic       sv, busy, pd, err;
   } vec_t;
   vec_t tbl[$];

   chan_scanner #(.DWELL_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
      .i_single(single), .i_en_mask(en_mask), .i_dwell(dwell),
      .o_s(s), .o_s_valid(s_valid), .o_busy(busy),
      .o_pass_done(pass_done), .o_err_nomask(err_nomask)
   );

   always #5 clk = ~clk;

   function automatic void add(input string nm, input logic rn, st, sp, sg,
                               input logic [7:0] m, d, input logic [2:0] es,
                               input logic esv, eb, epd, ee);
      vec_t v;
      v.name = nm; v.rst_n = rn; v.start = st; v.stop = sp; v.single = sg;
      v.mask = m; v.dwell = d; v.s = es; v.sv = esv; v.busy = eb; v.pd = epd; v.err = ee;
      tbl.push_back(v);
   endfunction

   // one vector = inputs held over one rising edge, outputs checked 1ns after it
   task automatic apply(input vec_t v, input int row);
      rst_n = v.rst_n; start = v.start; stop = v.stop; single = v.single;
      en_mask = v.mask; dwell = v.dwell;
      @(posedge clk);
      #1;
      n_vec++;
      if (s !== v.s || s_valid !== v.sv || busy !== v.busy || pass_done !== v.pd || err_nomask !== v.err) begin
         n_err++;
         $display("FAIL %s row %0d: got s=%0d v=%b busy=%b pd=%b err=%b, want s=%0d v=%b busy=%b pd=%b err=%b",
                  v.name, row, s, s_valid, busy, pass_done, err_nomask, v.s, v.sv, v.busy, v.pd, v.err);
      end
   endtask

   initial begin
      vec_t v;
      add("reset", 0,0,0,0, 8'h00,8'd0, 0,0,0,0,0);
      add("ff_start", 1,1,0,1, 8'hFF,8'd0, 0,1,1,0,0);
      for (int i = 1; i < 8; i++) add("ff_step", 1,0,0,0, 8'h00,8'd0, 3'(i),1,1,0,0);
      add("ff_end", 1,0,0,0, 8'h00,8'd0, 0,0,0,1,0);
      add("ff_idle", 1,0,0,0, 8'h00,8'd0, 0,0,0,0,0);
      add("nomask", 1,1,0,0, 8'h00,8'd3, 0,0,0,0,1);
      add("nomask_end", 1,0,0,0, 8'h00,8'd0, 0,0,0,0,0);
      add("start_stop", 1,1,1,0, 8'hFF,8'd0, 0,0,0,0,0);
      add("a4_start", 1,1,0,0, 8'hA4,8'd2, 2,1,1,0,0);
      add("a4", 1,0,0,0, 8'h00,8'd0, 2,1,1,0,0);
      add("a4", 1,1,0,1, 8'h01,8'd0, 2,1,1,0,0);
      add("a4", 1,1,0,1, 8'h01,8'd0, 5,1,1,0,0);
      add("a4", 1,0,0,0, 8'h01,8'd0, 5,1,1,0,0);
      add("a4", 1,1,0,0, 8'h01,8'd0, 5,1,1,0,0);
      add("a4", 1,0,0,0, 8'h00,8'd0, 7,1,1,0,0);
      add("a4", 1,0,0,0, 8'h00,8'd0, 7,1,1,0,0);
      add("a4", 1,1,0,0, 8'h01,8'd0, 7,1,1,0,0);
      add("a4_wrap", 1,0,0,0, 8'h00,8'd0, 2,1,1,1,0);
      add("a4", 1,0,0,0, 8'h00,8'd0, 2,1,1,0,0);
      add("a4", 1,0,0,0, 8'h00,8'd0, 2,1,1,0,0);
      add("a4", 1,0,0,0, 8'h00,8'd0, 5,1,1,0,0);
      add("a4_stop", 1,0,1,0, 8'h00,8'd0, 0,0,0,0,0);
      add("81_start", 1,1,0,0, 8'h81,8'd3, 0,1,1,0,0);
      add("81", 1,0,0,0, 8'h00,8'd0, 0,1,1,0,0);
      add("81", 1,0,0,0, 8'h00,8'd0, 0,1,1,0,0);
      add("81", 1,0,0,0, 8'h00,8'd0, 0,1,1,0,0);
      add("81", 1,0,0,0, 8'h00,8'd0, 7,1,1,0,0);
      add("81", 1,0,0,0, 8'h00,8'd0, 7,1,1,0,0);
      add("81_stop", 1,0,1,0, 8'h00,8'd0, 0,0,0,0,0);
      add("81d0_start", 1,1,0,0, 8'h81,8'd0, 0,1,1,0,0);
      add("81d0", 1,0,0,0, 8'h00,8'd0, 7,1,1,0,0);
      add("stop_at_wrap", 1,0,1,0, 8'h00,8'd0, 0,0,0,0,0);
      add("one_start", 1,1,0,0, 8'h10,8'd1, 4,1,1,0,0);
      add("one", 1,0,0,0, 8'h00,8'd0, 4,1,1,0,0);
      add("one_pass", 1,0,0,0, 8'h00,8'd0, 4,1,1,1,0);
      add("one", 1,0,0,0, 8'h00,8'd0, 4,1,1,0,0);
      add("one_pass", 1,0,0,0, 8'h00,8'd0, 4,1,1,1,0);
      add("one_stop", 1,0,1,0, 8'h00,8'd0, 0,0,0,0,0);
      add("0a_start", 1,1,0,0, 8'h0A,8'd1, 1,1,1,0,0);
      add("0a", 1,0,0,0, 8'h00,8'd0, 1,1,1,0,0);
      add("0a", 1,0,0,0, 8'h00,8'd0, 3,1,1,0,0);
      add("rst_mid", 0,1,0,0, 8'h0A,8'd1, 0,0,0,0,0);
      add("released", 1,0,0,0, 8'h00,8'd0, 0,0,0,0,0);
      add("restart", 1,1,0,0, 8'h0A,8'd1, 1,1,1,0,0);
      add("restart_stop", 1,0,1,0, 8'h00,8'd0, 0,0,0,0,0);
      for (int r = 0; r < tbl.size(); r++) apply(tbl[r], r);
      // maximum dwell: channel 0 held 256 cycles, then single pass ends
      v = '{"maxd_start", 1,1,0,1, 8'h01,8'd255, 0,1,1,0,0};
      apply(v, 0);
      for (int i = 1; i < 256; i++) begin
         v = '{"maxd_hold", 1,0,0,0, 8'h00,8'd0, 0,1,1,0,0};
         apply(v, i);
      end
      v = '{"maxd_end", 1,0,0,0, 8'h00,8'd0, 0,0,0,1,0};
      apply(v, 256);
      v = '{"maxd_idle", 1,0,0,0, 8'h00,8'd0, 0,0,0,0,0};
      apply(v, 257);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
